// File: rtl/reg_file_wb_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_wb_pkg
// Shared constants and types for the integer register file and the write-back
// stage. The index and word types are also used by the decoder, the immediate
// unit and the result-select logic.
//
// Optional feature macro used by files importing this package:
//   REGFILE_WB_BYPASS_EN  - write-through bypass on the read ports and busy
//                           flags (zero-cycle write-to-read visibility).
// -----------------------------------------------------------------------------
package reg_file_wb_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // x0 is hardwired: writes and reservations to it are discarded.
    function automatic logic is_arch_reg(input reg_idx_t idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register pending mask. A multi-cycle load reserves its destination; the
// matching write-back clears it. Readers see Busy1/Busy2 and the merged Stall.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   RegWrite, A3      write-back strobe and destination (clears pending)
//   Reserve, ARes     reservation strobe and index (sets pending)
//   A1, A2            read indices to query
//   Busy1, Busy2      pending status of A1 / A2
//   Stall             Busy1 | Busy2
//
// Optional feature macro: REGFILE_WB_BYPASS_EN - an index being written this
// cycle is reported not busy, unless the same cycle also reserves it.
//
// Handshake: there is no valid/ready pair here. Reserve and RegWrite are
// single-cycle strobes sampled on the rising clock edge; Busy/Stall are
// combinational and must be honoured by the issuing stage in the same cycle.
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     RegWrite,
    input  reg_idx_t A3,
    input  logic     Reserve,
    input  reg_idx_t ARes,
    input  reg_idx_t A1,
    input  reg_idx_t A2,
    output logic     Busy1,
    output logic     Busy2,
    output logic     Stall
);

    logic [NREG-1:0] r_pending;
    logic            w_clr;
    logic            w_set;

    assign w_clr = RegWrite && is_arch_reg(A3);
    assign w_set = Reserve  && is_arch_reg(ARes);

    // Set is applied after clear so a new load to rd issued while an older
    // result for rd retires keeps rd pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_clr) r_pending[A3]   <= 1'b0;
            if (w_set) r_pending[ARes] <= 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // An index retiring this cycle is already readable through the bypass,
    // so it only stays busy if it is simultaneously re-reserved.
    logic w_retire_only;
    assign w_retire_only = w_clr && !(w_set && (ARes == A3));
    assign Busy1 = r_pending[A1] && !(w_retire_only && (A1 == A3));
    assign Busy2 = r_pending[A2] && !(w_retire_only && (A2 == A3));
`else
    assign Busy1 = r_pending[A1];
    assign Busy2 = r_pending[A2];
`endif

    assign Stall = Busy1 | Busy2;

endmodule

// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
// 32 x 32-bit integer register file at the end of the datapath. The selected
// write-back result (ALU, load data, PC+4 or immediate) is written on the
// rising clock edge; two asynchronous read ports feed the ALU and store-data
// paths. A pending scoreboard stalls readers of registers awaiting load data.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   RegWrite, A3, WD3 write-back port (enable, destination, data)
//   A1 -> RD1         read port 1 (rs1), combinational
//   A2 -> RD2         read port 2 (rs2), combinational
//   Reserve, ARes     mark ARes pending (load issued)
//   Busy1, Busy2      A1 / A2 pending
//   Stall             Busy1 | Busy2
//
// Optional feature macro: REGFILE_WB_BYPASS_EN - write-through bypass from WD3
// to RD1/RD2 when the read index matches the register being written.
//
// Handshake: no valid/ready. RegWrite and Reserve are strobes sampled at the
// rising edge; read data and busy flags are valid combinationally from A1/A2.
// -----------------------------------------------------------------------------
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     RegWrite,
    input  reg_idx_t A3,
    input  word_t    WD3,
    input  reg_idx_t A1,
    input  reg_idx_t A2,
    output word_t    RD1,
    output word_t    RD2,
    input  logic     Reserve,
    input  reg_idx_t ARes,
    output logic     Busy1,
    output logic     Busy2,
    output logic     Stall
);

    word_t r_regs [NREG];
    logic  w_we;
    word_t w_rd1;
    word_t w_rd2;

    assign w_we = RegWrite && is_arch_reg(A3);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[A3] <= WD3;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Bypass is gated by rst so reads are zero for the whole reset window.
    assign w_rd1 = !is_arch_reg(A1)            ? '0  :
                   (w_we && !rst && A1 == A3)  ? WD3 : r_regs[A1];
    assign w_rd2 = !is_arch_reg(A2)            ? '0  :
                   (w_we && !rst && A2 == A3)  ? WD3 : r_regs[A2];
`else
    assign w_rd1 = !is_arch_reg(A1) ? '0 : r_regs[A1];
    assign w_rd2 = !is_arch_reg(A2) ? '0 : r_regs[A2];
`endif

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .A3       (A3),
        .Reserve  (Reserve),
        .ARes     (ARes),
        .A1       (A1),
        .A2       (A2),
        .Busy1    (Busy1),
        .Busy2    (Busy2),
        .Stall    (Stall)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;
  import reg_file_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic     reg_write = 1'b0;
  reg_idx_t a3 = '0;
  word_t    wd3 = '0;
  reg_idx_t a1 = '0;
  reg_idx_t a2 = '0;
  word_t    rd1;
  word_t    rd2;
  logic     reserve = 1'b0;
  reg_idx_t ares = '0;
  logic     busy1;
  logic     busy2;
  logic     stall;

  reg_file_wb dut (
    .clk      (clk),
    .rst      (rst),
    .RegWrite (reg_write),
    .A3       (a3),
    .WD3      (wd3),
    .A1       (a1),
    .A2       (a2),
    .RD1      (rd1),
    .RD2      (rd2),
    .Reserve  (reserve),
    .ARes     (ares),
    .Busy1    (busy1),
    .Busy2    (busy2),
    .Stall    (stall)
  );

  // ---------------- reference model ----------------
  // Architectural state only: contents and pending flag per register.
  word_t mdl_mem  [32];
  bit    mdl_pend [32];

  int checks   = 0;
  int failures = 0;

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) begin
      mdl_mem[i]  = '0;
      mdl_pend[i] = 1'b0;
    end
  endtask

  // Applied at each rising edge using the inputs held across that edge.
  task automatic mdl_edge();
    if (reg_write && a3 != 0) begin
      mdl_mem[a3]  = wd3;
      mdl_pend[a3] = 1'b0;
    end
    if (reserve && ares != 0) mdl_pend[ares] = 1'b1;
  endtask

  function automatic word_t exp_rd(input reg_idx_t a);
    if (a == 0) return '0;
    if (rst) return '0;
`ifdef REGFILE_WB_BYPASS_EN
    if (reg_write && a3 != 0 && a == a3) return wd3;
`endif
    return mdl_mem[a];
  endfunction

  function automatic logic exp_busy(input reg_idx_t a);
    if (a == 0 || rst) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    if (reg_write && a3 != 0 && a == a3 && !(reserve && ares == a3)) return 1'b0;
`endif
    return mdl_pend[a];
  endfunction

  // ---------------- scoreboard / checker ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic eb1, eb2;
    eb1 = exp_busy(a1);
    eb2 = exp_busy(a2);
    chk({tag, ".rd1"},   rd1,   exp_rd(a1));
    chk({tag, ".rd2"},   rd2,   exp_rd(a2));
    chk({tag, ".busy1"}, {31'b0, busy1}, {31'b0, eb1});
    chk({tag, ".busy2"}, {31'b0, busy2}, {31'b0, eb2});
    chk({tag, ".stall"}, {31'b0, stall}, {31'b0, eb1 | eb2});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic idle();
    reg_write = 1'b0;
    reserve   = 1'b0;
  endtask

  task automatic wr(input reg_idx_t idx, input word_t data);
    reg_write = 1'b1; a3 = idx; wd3 = data;
    step();
    reg_write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mdl_reset();
    #12;
    chk("reset.rd1", rd1, 32'h0);
    chk("reset.stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-cycle discards a written value at once.
    a1 = 5'd5;
    wr(5'd5, 32'hDEADBEEF);
    chk("pre_rst.rd1", rd1, 32'hDEADBEEF);
    reserve = 1'b1; ares = 5'd5; step(); idle();
    chk("pre_rst.busy1", {31'b0, busy1}, 32'h1);
    #2 rst = 1'b1;
    mdl_reset();
    #1;
    chk("async_rst.rd1", rd1, 32'h0);
    chk("async_rst.busy1", {31'b0, busy1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // x0 protection.
    a1 = 5'd0;
    wr(5'd0, 32'hFFFFFFFF);
    chk("x0.rd1", rd1, 32'h0);
    reserve = 1'b1; ares = 5'd0; step(); idle();
    chk("x0.busy1", {31'b0, busy1}, 32'h0);

    // Basic write/read.
    a1 = 5'd7; a2 = 5'd8;
    wr(5'd7, 32'h12345678);
    chk("basic.rd1", rd1, 32'h12345678);
    wr(5'd8, 32'hCAFEF00D);
    chk("basic.rd2", rd2, 32'hCAFEF00D);
    check_all("basic");

    // Same-cycle read of the write target.
    a1 = 5'd3;
    wr(5'd3, 32'h11);
    reg_write = 1'b1; a3 = 5'd3; wd3 = 32'h22;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("rdw.before", rd1, 32'h22);
`else
    chk("rdw.before", rd1, 32'h11);
`endif
    step(); idle();
    chk("rdw.after", rd1, 32'h22);

    // Scoreboard load: reserve x10, 3 idle cycles, then write-back.
    a2 = 5'd10;
    reserve = 1'b1; ares = 5'd10;
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      chk("load.busy2", {31'b0, busy2}, 32'h1);
      chk("load.stall", {31'b0, stall}, 32'h1);
      if (i < 3) step();
    end
    wr(5'd10, 32'hA5A5A5A5);
    chk("load.busy2_clr", {31'b0, busy2}, 32'h0);
    chk("load.stall_clr", {31'b0, stall}, 32'h0);
    chk("load.rd2", rd2, 32'hA5A5A5A5);

    // Collision: write and reserve of x4 in the same cycle keeps it pending.
    a1 = 5'd4; a2 = 5'd9;
    reserve = 1'b1; ares = 5'd4; step(); idle();
    reg_write = 1'b1; a3 = 5'd4; wd3 = 32'h44444444;
    reserve = 1'b1; ares = 5'd4;
    step(); idle();
    chk("coll.rd1", rd1, 32'h44444444);
    chk("coll.busy1", {31'b0, busy1}, 32'h1);
    // Write x4 while reserving x9.
    reg_write = 1'b1; a3 = 5'd4; wd3 = 32'h55555555;
    reserve = 1'b1; ares = 5'd9;
    step(); idle();
    chk("split.busy1", {31'b0, busy1}, 32'h0);
    chk("split.busy2", {31'b0, busy2}, 32'h1);
    chk("split.rd1", rd1, 32'h55555555);

    // Randomized traffic on a narrow index range to force collisions.
    for (int n = 0; n < 400; n++) begin
      reg_write = ($urandom_range(0, 99) < 50);
      a3        = reg_idx_t'($urandom_range(0, 7));
      wd3       = $urandom;
      reserve   = ($urandom_range(0, 99) < 30);
      ares      = reg_idx_t'($urandom_range(0, 7));
      a1        = reg_idx_t'($urandom_range(0, 7));
      a2        = ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom_range(0, 31))
                                              : reg_idx_t'($urandom_range(0, 7));
      #1;
      check_all("rand.pre");
      step();
      check_all("rand.post");
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        mdl_reset();
        #1;
        check_all("rand.rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
